// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller slice.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
  typedef enum logic {CORE = 1'b0, LDR = 1'b1} grant_t;

  localparam int DMEM_WORDS = 128;

  // funct3[1:0] encoding; the unused 2'b11 code is treated as a word.
  function automatic size_t to_size(input logic [1:0] f);
    case (f)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester and RAM-side signals of dmem_ctrl; core_err exists only with DMEM_MISALIGN_CHECK_EN.
interface dmem_ctrl_if #(
  parameter int Width      = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter int ADDR_W     = 32
);
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_W-1:0]     core_addr;
  logic [1:0]            core_size;
  logic                  core_unsigned;
  logic [Width-1:0]      core_wdata;
  logic [Width-1:0]      core_rdata;
  logic                  core_done;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic                  core_err;
`endif
  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_W-1:0]     ld_addr;
  logic [Width-1:0]      ld_wdata;
  logic [Width-1:0]      ld_rdata;
  logic                  ld_done;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_a;
  logic [Width-1:0]      mem_wd;
  logic [Width-1:0]      mem_rd;
  logic                  busy;

  modport slave (
    input  core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, mem_rd,
    output core_rdata, core_done, ld_rdata, ld_done, mem_we, mem_a, mem_wd,
`ifdef DMEM_MISALIGN_CHECK_EN
    output core_err,
`endif
    output busy
  );

  modport master (
    output core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, mem_rd,
    input  core_rdata, core_done, ld_rdata, ld_done, mem_we, mem_a, mem_wd,
`ifdef DMEM_MISALIGN_CHECK_EN
    input  core_err,
`endif
    input  busy
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte-lane logic: load extraction/extension and sub-word store merge into a RAM word.
module dmem_lane
  import dmem_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [Width-1:0] word,
  input  logic [1:0]       off,
  input  size_t            size,
  input  logic             uns,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] ld_data,
  output logic [Width-1:0] st_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word[8*off +: 8];
    h       = off[1] ? word[31:16] : word[15:0];
    ld_data = word;
    st_data = wdata;
    case (size)
      SZ_B: begin
        ld_data               = {{(Width-8){b[7] & ~uns}}, b};
        st_data               = word;
        st_data[8*off +: 8]   = wdata[7:0];
      end
      SZ_H: begin
        ld_data = {{(Width-16){h[15] & ~uns}}, h};
        st_data = word;
        if (off[1]) st_data[31:16] = wdata[15:0];
        else        st_data[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin data-memory controller (core + loader) with byte/half/word access and RMW stores.
// Optional misaligned-access trap: DMEM_MISALIGN_CHECK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int Width      = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter int ADDR_W     = 32
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);

  state_t                state, state_nxt;
  grant_t                last_grant, sel, grant_p;
  logic                  grant_v;
  logic                  we_r, uns_r, mis_r, g_we, g_uns, g_mis;
  logic [DEPTH_LOG2-1:0] wa_r, g_wa;
  logic [1:0]            off_r, g_off;
  size_t                 size_r, g_size;
  logic [Width-1:0]      wdata_r, rdata_r, merged_r, g_wdata, lane_ld, lane_st;
  logic                  unused_addr_bits;

  // Upper address bits alias; loader low bits are always word-aligned.
  assign unused_addr_bits = ^{bus.core_addr[ADDR_W-1:DEPTH_LOG2+2],
                              bus.ld_addr[ADDR_W-1:DEPTH_LOG2+2], bus.ld_addr[1:0]};

  always_comb begin
    grant_v = bus.core_req | bus.ld_req;
    grant_p = CORE;
    if (bus.core_req && bus.ld_req) grant_p = (last_grant == CORE) ? LDR : CORE;
    else if (bus.ld_req)            grant_p = LDR;
    if (grant_p == LDR) begin
      g_we    = bus.ld_we;
      g_wa    = bus.ld_addr[DEPTH_LOG2+1:2];
      g_off   = 2'b00;
      g_size  = SZ_W;
      g_uns   = 1'b0;
      g_wdata = bus.ld_wdata;
    end else begin
      g_we    = bus.core_we;
      g_wa    = bus.core_addr[DEPTH_LOG2+1:2];
      g_off   = bus.core_addr[1:0];
      g_size  = to_size(bus.core_size);
      g_uns   = bus.core_unsigned;
      g_wdata = bus.core_wdata;
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    g_mis = (grant_p == CORE) &&
            (((g_size == SZ_H) && g_off[0]) || ((g_size == SZ_W) && (g_off != 2'b00)));
`else
    g_mis = 1'b0;
`endif
  end

  dmem_lane #(.Width(Width)) u_lane (
    .word    (bus.mem_rd),
    .off     (off_r),
    .size    (size_r),
    .uns     (uns_r),
    .wdata   (wdata_r),
    .ld_data (lane_ld),
    .st_data (lane_st)
  );

  // Write enables are gated by reset so an abandoned access never reaches the RAM.
  always_comb begin
    state_nxt  = state;
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    case (state)
      IDLE:   if (grant_v) state_nxt = ACCESS;
      ACCESS: begin
        bus.mem_a = wa_r;
        if (we_r && (size_r == SZ_W)) begin
          bus.mem_we = ~mis_r & ~reset;
          bus.mem_wd = wdata_r;
          state_nxt  = RESP;
        end else if (we_r) begin
          state_nxt  = WRITE;
        end else begin
          state_nxt  = RESP;
        end
      end
      WRITE: begin
        bus.mem_a  = wa_r;
        bus.mem_we = ~mis_r & ~reset;
        bus.mem_wd = merged_r;
        state_nxt  = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CORE;
      sel        <= CORE;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      mis_r      <= 1'b0;
      wa_r       <= '0;
      off_r      <= '0;
      size_r     <= SZ_B;
      wdata_r    <= '0;
      rdata_r    <= '0;
      merged_r   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_v) begin
        last_grant <= grant_p;
        sel        <= grant_p;
        we_r       <= g_we;
        uns_r      <= g_uns;
        mis_r      <= g_mis;
        wa_r       <= g_wa;
        off_r      <= g_off;
        size_r     <= g_size;
        wdata_r    <= g_wdata;
      end
      if (state == ACCESS) begin
        merged_r <= lane_st;
        if (mis_r)      rdata_r <= '0;
        else if (!we_r) rdata_r <= lane_ld;
      end
    end
  end

  assign bus.core_done  = (state == RESP) && (sel == CORE);
  assign bus.ld_done    = (state == RESP) && (sel == LDR);
  assign bus.core_rdata = rdata_r;
  assign bus.ld_rdata   = rdata_r;
  assign bus.busy       = (state != IDLE);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.core_err   = (state == RESP) && (sel == CORE) && mis_r;
`endif

endmodule
